// File: rtl/mult_pkg.sv
// Definitions shared by the 4-bit multiplier and its product accumulator back end.
package mult_pkg;

    localparam int PROD_W = 8;
    localparam int CNT_W  = 8;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

endpackage : mult_pkg

// File: rtl/product_accumulator.sv
// Sums FRAME_LEN unsigned products per frame and holds each result on a
// valid/ready output until the consumer takes it.
module product_accumulator #(
    parameter int PROD_W    = mult_pkg::PROD_W,
    parameter int ACC_W     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PROD_W-1:0]           product,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            sum,
    output logic                        overflow,
    output logic [mult_pkg::CNT_W-1:0]  beat_cnt
);

    import mult_pkg::*;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    logic [0:0]       state_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] sum_r;
    logic             overflow_r;
    logic             sticky_r;

    logic             accept_s;
    logic             last_beat_s;
    logic             handshake_s;
    logic [ACC_W:0]   acc_ext_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic             carry_s;

    // Handshake decode and the widened add whose top bit is the frame carry.
    always_comb begin
        accept_s    = 1'b0;
        handshake_s = 1'b0;
        if (state_r == ST_ACC) begin
            accept_s = in_valid;
        end else begin
            handshake_s = out_ready;
        end
        last_beat_s = (beat_cnt_r == LAST_BEAT);
        acc_ext_s   = {1'b0, acc_r} + (ACC_W + 1)'(product);
        acc_nxt_s   = acc_ext_s[ACC_W-1:0];
        carry_s     = acc_ext_s[ACC_W];
    end

    // FSM and beat counter; clear overrides any same-cycle accept or handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_ACC;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            state_r    <= ST_ACC;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (accept_s && last_beat_s) begin
                        state_r    <= ST_DONE;
                        beat_cnt_r <= {CNT_W{1'b0}};
                    end else if (accept_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                ST_DONE: begin
                    if (handshake_s) begin
                        state_r <= ST_ACC;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r    <= ST_ACC;
                    beat_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Accumulator, sticky wrap flag and the held frame result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {ACC_W{1'b0}};
            sum_r      <= {ACC_W{1'b0}};
            overflow_r <= 1'b0;
            sticky_r   <= 1'b0;
        end else if (clear) begin
            acc_r    <= {ACC_W{1'b0}};
            sticky_r <= 1'b0;
        end else if (accept_s && last_beat_s) begin
            sum_r      <= acc_nxt_s;
            overflow_r <= sticky_r | carry_s;
            acc_r      <= {ACC_W{1'b0}};
            sticky_r   <= 1'b0;
        end else if (accept_s) begin
            acc_r    <= acc_nxt_s;
            sticky_r <= sticky_r | carry_s;
        end else begin
            acc_r    <= acc_r;
            sticky_r <= sticky_r;
        end
    end

    // Handshake flags are a direct decode of the state register, so they are glitch-free.
    assign in_ready  = (state_r == ST_ACC);
    assign out_valid = (state_r == ST_DONE);
    assign sum       = sum_r;
    assign overflow  = overflow_r;
    assign beat_cnt  = beat_cnt_r;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Directed and randomized frames driven into a 16-bit and a 9-bit accumulator in lockstep.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [7:0]  product;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, overflow_a;
    logic [15:0] sum_a;
    logic [7:0]  beat_cnt_a;
    logic        in_ready_b, out_valid_b, overflow_b;
    logic [8:0]  sum_b;
    logic [7:0]  beat_cnt_b;

    int checks   = 0;
    int failures = 0;
    int total    = 0;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(8), .ACC_W(16), .FRAME_LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a), .product(product),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .sum(sum_a), .overflow(overflow_a), .beat_cnt(beat_cnt_a)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(9), .FRAME_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b), .product(product),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .sum(sum_b), .overflow(overflow_b), .beat_cnt(beat_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one product after `gap` idle cycles; returns at the negedge after it was taken.
    task automatic beat(input logic [7:0] p, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            product  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        product  = p;
        n = 0;
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready_a}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        product  = 8'($urandom);
        total    = total + int'(p);
    endtask

    // Check a finished frame against the model total, stall `stall` cycles, then accept it.
    task automatic take(input string tag, input int stall);
        int n;
        logic [15:0] held;
        n = 0;
        while (!out_valid_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid_a}, 32'd1);
        chk({tag, "_sum16"}, {16'd0, sum_a}, 32'(total % 65536));
        chk({tag, "_ovf16"}, {31'd0, overflow_a}, {31'd0, total >= 65536});
        chk({tag, "_sum9"}, {23'd0, sum_b}, 32'(total % 512));
        chk({tag, "_ovf9"}, {31'd0, overflow_b}, {31'd0, total >= 512});
        held = sum_a;
        repeat (stall) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            product   = 8'($urandom);
            @(negedge clk);
            chk({tag, "_hold_sum"}, {16'd0, sum_a}, {16'd0, held});
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready_a}, 32'd0);
            chk({tag, "_hold_valid"}, {31'd0, out_valid_a}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_released"}, {31'd0, out_valid_a}, 32'd0);
        chk({tag, "_in_ready_back"}, {31'd0, in_ready_a}, 32'd1);
        total = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        product   = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_sum", {16'd0, sum_a}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_a}, 32'd0);
        chk("rst_beat_cnt", {24'd0, beat_cnt_a}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, then backpressure for 5 cycles.
        beat(8'd1, 0); beat(8'd4, 0); beat(8'd9, 0); beat(8'd25, 0);
        chk("basic_total_model", 32'(total), 32'd39);
        take("basic", 5);

        // Max products with 0..3 cycle gaps; beat counter walks 1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            beat(8'd225, i);
            chk("max_beat_cnt", {24'd0, beat_cnt_a}, 32'((i + 1) % 4));
        end
        take("max", 0);

        // Wrap in the 9-bit build, then a clean frame.
        beat(8'd225, 0); beat(8'd225, 0); beat(8'd225, 0); beat(8'd0, 0);
        take("ovf", 1);
        beat(8'd1, 0); beat(8'd1, 0); beat(8'd1, 0); beat(8'd1, 0);
        take("after_ovf", 0);

        // Abort mid-frame with a same-cycle offered product.
        beat(8'd25, 0); beat(8'd36, 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        product  = 8'd5;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_beat_cnt", {24'd0, beat_cnt_a}, 32'd0);
        chk("clear_in_ready", {31'd0, in_ready_a}, 32'd1);
        total = 0;
        beat(8'd1, 0); beat(8'd1, 0); beat(8'd1, 0); beat(8'd1, 0);
        take("abort", 0);

        // Clear while a result is pending: output drops, sum register kept.
        beat(8'd7, 0); beat(8'd8, 0); beat(8'd9, 0); beat(8'd10, 0);
        out_ready = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        out_ready = 1'b0;
        chk("clear_done_valid", {31'd0, out_valid_a}, 32'd0);
        chk("clear_done_sum_kept", {16'd0, sum_a}, 32'd34);
        total = 0;

        // Asynchronous reset mid-frame.
        beat(8'd30, 0); beat(8'd78, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_beat_cnt", {24'd0, beat_cnt_a}, 32'd0);
        chk("arst_sum", {16'd0, sum_a}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready_a}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        total = 0;
        @(negedge clk);
        beat(8'd130, 0); beat(8'd210, 0); beat(8'd0, 0); beat(8'd0, 0);
        chk("arst_total_model", 32'(total), 32'd340);
        take("post_reset", 2);

        // Randomized frames with random gaps and backpressure.
        for (int f = 0; f < 20; f++) begin
            for (int b = 0; b < 4; b++) begin
                beat(8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
            end
            take("rand", int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_product_accumulator
